regfile_wb_sched: RTL and testbench

- Write-back scheduler and scoreboard in front of the physical register file's single write port (ard/drd).
- Arbitrates up to N_REQ result producers (e.g. ALU, FPU, load unit) round-robin onto that port, one write per cycle.
- Tracks a per-register busy bit so that issue stalls on RAW/WAW hazards against in-flight destinations.

---
 rtl/regfile_wb_sched.sv | 136 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and busy-bit scoreboard in front of the single
// register-file write port.
//
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   issue_valid/rd/rs1/rs2      instruction presented by decode
//   issue_stall                 RAW/WAW hazard, issue not taken (comb)
//   req_valid/rd/data           packed write-back requests, N_REQ lanes
//   req_ready                   one-hot round-robin grant (comb)
//   ard, drd                    registered write port (ard=0: no write)
//   stall_cnt, conflict_cnt     saturating event counters, present only
//                               when WB_STALL_CNT_EN is defined
`ifndef LEN_PREG_ADDR
`define LEN_PREG_ADDR 6
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module regfile_wb_sched #(
  parameter int N_REQ    = 3,
  parameter int LEN_ADDR = `LEN_PREG_ADDR,
  parameter int LEN_WORD = `LEN_WORD
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      issue_valid,
  input  logic [LEN_ADDR-1:0]       issue_rd,
  input  logic [LEN_ADDR-1:0]       issue_rs1,
  input  logic [LEN_ADDR-1:0]       issue_rs2,
  output logic                      issue_stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*LEN_ADDR-1:0] req_rd,
  input  logic [N_REQ*LEN_WORD-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [LEN_ADDR-1:0]       ard,
  output logic [LEN_WORD-1:0]       drd
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               conflict_cnt
`endif
);

  localparam int N_REG = 2 ** LEN_ADDR;
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REG-1:0]    busy;
  logic [N_REG-1:0]    busy_d;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       win;
  logic [IW-1:0]       cand;
  logic                found;
  logic                accept;
  logic [LEN_ADDR-1:0] win_rd;
  logic [LEN_WORD-1:0] win_data;

  assign issue_stall = issue_valid &
    (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);

  assign accept = issue_valid & ~issue_stall;

  // Search starts one past the previous winner.
  always_comb begin
    req_ready = '0;
    win       = last_grant;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found           = 1'b1;
        win             = cand;
        req_ready[cand] = 1'b1;
      end
    end
  end

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        win_rd   = req_rd[i*LEN_ADDR +: LEN_ADDR];
        win_data = req_data[i*LEN_WORD +: LEN_WORD];
      end
    end
  end

  // Clear applied before set so a same-edge set of that register wins.
  always_comb begin
    busy_d = busy;
    if (ard != '0)
      busy_d[ard] = 1'b0;
    if (accept && issue_rd != '0)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy       <= '0;
      ard        <= '0;
      drd        <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else begin
      busy <= busy_d;
      if (found) begin
        ard        <= win_rd;
        drd        <= win_data;
        last_grant <= win;
      end else begin
        ard <= '0;
      end
    end
  end

`ifdef WB_STALL_CNT_EN
  logic conflict;

  assign conflict = $countones(req_valid) >= 2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (issue_stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (conflict && conflict_cnt != 32'hFFFF_FFFF)
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: round-robin grant model plus a
// scoreboard queue of expected ard/drd, one entry per clock cycle.
module tb_regfile_wb_sched;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            dc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic            issue_stall;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_rd;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   ard;
  logic [DW-1:0]   drd;
`ifdef WB_STALL_CNT_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     conflict_cnt;
`endif

  int   total  = 0;
  int   passed = 0;
  exp_t sbq[$];
  int   m_last = N - 1;
  logic [DW-1:0] m_drd = '0;
  bit   m_drd_dc = 1'b0;

  logic [N-1:0] seq_exp [4];

  regfile_wb_sched #(
    .N_REQ(N), .LEN_ADDR(AW), .LEN_WORD(DW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready),
    .ard(ard), .drd(drd)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] rr(input logic [N-1:0] v,
                                      input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic set_iss(input logic v, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2);
    issue_valid = v;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
  endtask

  // Settle inputs, check the grant, and queue next cycle's write port.
  task automatic drv();
    logic [N-1:0] g;
    exp_t e;
    #1;
    g = rr(req_valid, m_last);
    chk("req_ready", 64'(req_ready), 64'(g));
    if (!rstn) begin
      m_last   = N - 1;
      m_drd    = '0;
      m_drd_dc = 1'b0;
      e = '{a: '0, d: '0, dc: 1'b0};
    end else if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_last   = i;
          m_drd    = req_data[i*DW +: DW];
          m_drd_dc = (req_rd[i*AW +: AW] == '0);
          e.a  = req_rd[i*AW +: AW];
          e.d  = m_drd;
          e.dc = m_drd_dc;
        end
      end
    end else begin
      e = '{a: '0, d: m_drd, dc: m_drd_dc};
    end
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      $error("FAIL sbq_empty: observed empty expected entry");
    end else begin
      e = sbq.pop_front();
      chk("ard", 64'(ard), 64'(e.a));
      if (!e.dc) chk("drd", 64'(drd), 64'(e.d));
    end
  endtask

  initial begin
    seq_exp[0] = 3'b100;
    seq_exp[1] = 3'b001;
    seq_exp[2] = 3'b010;
    seq_exp[3] = 3'b100;
    rstn = 1'b0;
    req_valid = '0;
    req_rd = '0;
    req_data = '0;
    set_iss(1'b0, '0, '0, '0);
    drv(); chk("stall_idle", 64'(issue_stall), 64'd0); tick();
    drv(); tick();

    rstn = 1'b1;
    set_iss(1'b1, 6'd5, '0, '0);
    drv(); chk("iss_rd5", 64'(issue_stall), 64'd0); tick();
    set_iss(1'b1, '0, 6'd5, '0);
    drv(); chk("raw_rs1_5", 64'(issue_stall), 64'd1); tick();

    set_iss(1'b0, '0, 6'd5, '0);
    set_req(1, 6'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    drv();
    chk("grant_r1", 64'(req_ready), 64'(3'b010));
    chk("stall_novalid", 64'(issue_stall), 64'd0);
    tick();
    req_valid = '0;
    set_iss(1'b1, '0, 6'd5, '0);
    drv(); chk("stall_t1", 64'(issue_stall), 64'd1); tick();
    drv(); chk("stall_t2", 64'(issue_stall), 64'd0); tick();

    set_iss(1'b0, '0, '0, '0);
    set_req(0, 6'd7, 32'h70);
    set_req(1, 6'd8, 32'h80);
    set_req(2, 6'd9, 32'h90);
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      drv();
      chk($sformatf("rr_all_%0d", c), 64'(req_ready), 64'(seq_exp[c]));
      tick();
    end

    req_valid = 3'b001;
    drv(); chk("only0", 64'(req_ready), 64'(3'b001)); tick();
    req_valid = 3'b100;
    for (int c = 0; c < 3; c++) begin
      drv();
      chk($sformatf("only2_%0d", c), 64'(req_ready), 64'(3'b100));
      tick();
    end
    req_valid = 3'b101;
    drv(); chk("0_after_2", 64'(req_ready), 64'(3'b001)); tick();

    req_valid = '0;
    set_iss(1'b1, '0, '0, '0);
    drv(); chk("iss_rd0", 64'(issue_stall), 64'd0); tick();
    set_iss(1'b0, '0, '0, '0);
    set_req(0, '0, 32'h1234);
    req_valid = 3'b001;
    drv(); tick();
    req_valid = '0;
    set_iss(1'b1, '0, '0, '0);
    drv(); chk("rs1_0", 64'(issue_stall), 64'd0); tick();
    set_iss(1'b1, '0, 6'd7, 6'd8);
    drv(); chk("wb_notbusy", 64'(issue_stall), 64'd0); tick();

    set_iss(1'b0, '0, '0, '0);
    set_req(0, 6'd10, 32'hAAAA);
    req_valid = 3'b001;
    drv(); tick();
    req_valid = '0;
    set_iss(1'b1, 6'd10, '0, '0);
    drv(); chk("setclr_iss", 64'(issue_stall), 64'd0); tick();
    set_iss(1'b1, '0, 6'd10, '0);
    drv(); chk("set_wins", 64'(issue_stall), 64'd1); tick();

    set_iss(1'b1, 6'd3, '0, '0);
    drv(); chk("iss_rd3", 64'(issue_stall), 64'd0); tick();
    set_iss(1'b1, '0, 6'd3, '0);
    set_req(0, 6'd3, 32'h33);
    req_valid = 3'b001;
    rstn = 1'b0;
    drv();
    chk("rst_ready", 64'(req_ready), 64'(3'b001));
    chk("rst_stall", 64'(issue_stall), 64'd1);
    tick();
    rstn = 1'b1;
    req_valid = '0;
    drv();
    chk("busy3_clr", 64'(issue_stall), 64'd0);
`ifdef WB_STALL_CNT_EN
    chk("stall_cnt_rst", 64'(stall_cnt), 64'd0);
`endif
    tick();
    set_iss(1'b0, '0, '0, '0);
    set_req(0, 6'd1, 32'h11);
    set_req(1, 6'd2, 32'h22);
    req_valid = 3'b011;
    drv(); chk("rst_prio0", 64'(req_ready), 64'(3'b001)); tick();
    req_valid = '0;
    drv(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
